// File: rtl/sha256_message_schedule.sv
// SHA-256 message schedule: loads 16 words M[0..15], then streams W[0..63] from a 16-word sliding window.
// Latency: W0 is valid 1 cycle after the 16th accept. Backpressure: w_ready low holds outputs and window.
module sha256_message_schedule (
  input  logic        clock,
  input  logic        reset,
  input  logic        msg_valid,
  input  logic [31:0] msg_word,
  output logic        msg_ready,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_word,
  output logic [5:0]  w_index,
  output logic        w_last,
  output logic        busy
);

  typedef enum logic {LOAD, EMIT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  load_cnt;
  logic [5:0]  t;
  logic [31:0] window [16];
  logic [31:0] w_new;
  logic        load_hs, emit_hs;

  function automatic logic [31:0] s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign load_hs = msg_valid && (state_q == LOAD);
  assign emit_hs = w_ready && (state_q == EMIT);
  assign w_new   = s1(window[14]) + window[9] + s0(window[1]) + window[0];

  always_comb begin
    state_d   = state_q;
    msg_ready = 1'b0;
    w_valid   = 1'b0;
    case (state_q)
      LOAD: begin
        msg_ready = 1'b1;
        if (msg_valid && load_cnt == 4'd15) state_d = EMIT;
      end
      EMIT: begin
        w_valid = 1'b1;
        if (w_ready && t == 6'd63) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
    // Outputs read as idle for the whole reset cycle, whatever the registers hold.
    if (reset) begin
      msg_ready = 1'b1;
      w_valid   = 1'b0;
    end
    w_word  = reset ? 32'd0 : window[0];
    w_index = reset ? 6'd0 : t;
    w_last  = w_valid && (t == 6'd63);
    busy    = !reset && ((state_q == EMIT) || (load_cnt != 4'd0));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= LOAD;
      load_cnt <= 4'd0;
      t        <= 6'd0;
      for (int k = 0; k < 16; k++) window[k] <= 32'd0;
    end else begin
      state_q <= state_d;
      if (load_hs) begin
        window[load_cnt] <= msg_word;
        load_cnt         <= load_cnt + 4'd1;
      end
      // t and load_cnt wrap naturally back to 0 at the end of a block.
      if (emit_hs) begin
        for (int k = 0; k < 15; k++) window[k] <= window[k+1];
        window[15] <= w_new;
        t          <= t + 6'd1;
      end
    end
  end

endmodule

// File: doc/sha256_message_schedule.md
SHA256_MESSAGE_SCHEDULE -- requirements
Module: sha256_message_schedule

Interface
REQ-001 The block SHALL have no parameters; word width is fixed at 32 bits and schedule length at 64 words.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 msg_valid  input  1  msg_word carries a message word of the current block.
REQ-005 msg_word  input  32  message word M[i], loaded in order i=0..15.
REQ-006 msg_ready  output  1  block can accept a message word this cycle.
REQ-007 w_valid  output  1  w_word/w_index carry a valid schedule word.
REQ-008 w_ready  input  1  round-function consumer accepts the schedule word this cycle.
REQ-009 w_word  output  32  schedule word W[t].
REQ-010 w_index  output  6  t, the index of w_word, 0..63.
REQ-011 w_last  output  1  high together with w_valid when t=63.
REQ-012 busy  output  1  high in any state other than LOAD, or in LOAD with at least one word loaded.

Function
REQ-013 The block SHALL implement two states: LOAD and EMIT.
REQ-014 In LOAD: msg_ready=1 and w_valid=0; a load handshake (msg_valid && msg_ready) SHALL write msg_word into window slot load_cnt and increment load_cnt (0..15).
REQ-015 The handshake that accepts the 16th word (load_cnt=15) SHALL move the state to EMIT with t=0; w_valid SHALL rise on the next cycle, giving a latency of 1 cycle.
REQ-016 In EMIT: msg_ready=0, w_valid=1, w_word=window[0], w_index=t.
REQ-017 On an emit handshake (w_valid && w_ready), the block SHALL shift the window: window[k]<=window[k+1] for k=0..14, and window[15]<=Wnew.
REQ-018 Wnew SHALL equal s1(window[14]) + window[9] + s0(window[1]) + window[0], modulo 2^32, with all carries out of bit 31 discarded.
REQ-019 s0(x) SHALL equal ROTR7(x) ^ ROTR18(x) ^ SHR3(x); s1(x) SHALL equal ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
REQ-020 Each emit handshake SHALL increment t; the handshake at t=63 SHALL return the state to LOAD with load_cnt=0 and t=0.
REQ-021 While w_valid=1 and w_ready=0, w_word, w_index and w_last SHALL hold stable and the window SHALL NOT change.
REQ-022 msg_valid SHALL be ignored in EMIT; w_ready SHALL be ignored in LOAD.
REQ-023 At the cycle of the t=63 handshake, msg_ready SHALL remain 0; it rises on the following cycle.
REQ-024 The block SHALL sustain one emit handshake per cycle with w_ready held high, emitting 64 words in 64 consecutive cycles.
REQ-025 Wnew SHALL be computed combinationally from the window; the block SHALL require no extra pipeline cycles between emitted words.

Reset
REQ-026 When reset=1 at a rising edge, the block SHALL enter LOAD with load_cnt=0 and t=0, and all window registers SHALL be cleared to 0.
REQ-027 Output values during reset: msg_ready=1, w_valid=0, w_word=0, w_index=0, w_last=0, busy=0.
REQ-028 Reset SHALL take priority over any simultaneous handshake.
REQ-029 Reset asserted mid-load or mid-emit SHALL discard the partial block; no further words of that block SHALL be emitted.

Verification
REQ-030 Load the "abc" block (M0=0x61626380, M1..M14=0, M15=0x00000018) with w_ready=1 -> W0..W15 equal the inputs, W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB with w_last=1; 64 consecutive w_valid cycles.
REQ-031 Same block with w_ready toggling randomly (50%) -> identical W sequence and indices; outputs stable while stalled.
REQ-032 Load 16 words with msg_valid gaps -> first w_valid exactly 1 cycle after the 16th accept; msg_ready=0 throughout EMIT.
REQ-033 Assert reset after 7 loaded words, then load a fresh full block -> output matches the fresh block only; w_valid stays 0 until the fresh block is loaded.
REQ-034 Assert reset at t=30 during EMIT -> the next cycle has w_valid=0 and msg_ready=1; the next block starts at w_index=0.
REQ-035 Load two blocks back-to-back with msg_valid held high -> msg_ready=1 one cycle after the t=63 accept; the second block's schedule matches the software model.
